// File: rtl/msrv_32_fetch_unit.sv
// Instruction fetch stage for the MSRV32 core.
// Owns the PC, issues word fetches on a req/ready handshake, and buffers the
// returned words in an in-order queue. Redirects flush the queue and mark the
// in-flight responses as stale so that they are dropped.
module msrv_32_fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,  // must be word-aligned
  parameter int unsigned DEPTH    = 2                // power of two, >= 2
) (
  input  logic        ms_riscv32_mp_clk_in,
  input  logic        ms_riscv32_mp_rst_n_in,
  output logic        imem_req_out,
  output logic [31:0] imem_addr_out,
  input  logic        imem_ready_in,
  input  logic        imem_rvalid_in,
  input  logic [31:0] imem_rdata_in,
  output logic        instr_valid_out,
  output logic [31:0] instr_out,
  output logic [31:0] pc_out,
  input  logic        instr_ready_in,
  input  logic        redirect_in,
  input  logic [31:0] redirect_pc_in
);

  localparam int unsigned PW = $clog2(DEPTH);
  localparam int unsigned CW = $clog2(DEPTH) + 1;
  localparam logic [CW:0] DEPTH_C = (CW + 1)'(DEPTH);

  typedef enum logic {StBoot, StRun} state_t;

  state_t        state_q;
  logic [31:0]   fetch_pc_q, fetch_pc_d;
  logic [31:0]   resp_pc_q, resp_pc_d;
  logic [CW-1:0] count_q, count_d;
  logic [CW-1:0] inflight_q, inflight_d;
  logic [CW-1:0] stale_q, stale_d;
  logic [PW-1:0] rd_ptr_q, rd_ptr_d;
  logic [PW-1:0] wr_ptr_q, wr_ptr_d;
  logic [31:0]   instr_mem_q [DEPTH];
  logic [31:0]   pc_mem_q    [DEPTH];

  logic [CW:0]   credit;
  logic          accept;
  logic          push;
  logic          pop;
  logic [31:0]   redirect_target;
  logic          unused_redirect_lsbs;

  assign redirect_target      = {redirect_pc_in[31:2], 2'b00};
  assign unused_redirect_lsbs = ^redirect_pc_in[1:0];

  // Queued words plus outstanding fetches never exceed DEPTH, so a response
  // always has a free slot even when decode is stalled.
  assign credit        = {1'b0, count_q} + {1'b0, inflight_q};
  assign imem_req_out  = (state_q == StRun) & ~redirect_in & (credit < DEPTH_C);
  assign imem_addr_out = fetch_pc_q;
  assign accept        = imem_req_out & imem_ready_in;

  // A response arriving during a redirect belongs to the old stream.
  assign push = imem_rvalid_in & (stale_q == '0) & ~redirect_in;

  assign instr_valid_out = (count_q != '0) & ~redirect_in;
  assign instr_out       = instr_mem_q[rd_ptr_q];
  assign pc_out          = pc_mem_q[rd_ptr_q];
  assign pop             = instr_valid_out & instr_ready_in;

  // Boot/run sequencing: one idle cycle after reset release before fetching.
  always_ff @(posedge ms_riscv32_mp_clk_in or negedge ms_riscv32_mp_rst_n_in) begin
    if (!ms_riscv32_mp_rst_n_in) begin
      state_q <= StBoot;
    end else begin
      unique case (state_q)
        StBoot:  state_q <= StRun;
        StRun:   state_q <= StRun;
        default: state_q <= StBoot;
      endcase
    end
  end

  // Next-state for PCs, pointers and counters.
  always_comb begin
    inflight_d = inflight_q + CW'(accept) - CW'(imem_rvalid_in);
    stale_d    = stale_q;
    count_d    = count_q + CW'(push) - CW'(pop);
    rd_ptr_d   = rd_ptr_q + PW'(pop);
    wr_ptr_d   = wr_ptr_q + PW'(push);
    fetch_pc_d = accept ? fetch_pc_q + 32'd4 : fetch_pc_q;
    resp_pc_d  = push ? resp_pc_q + 32'd4 : resp_pc_q;

    if (imem_rvalid_in && (stale_q != '0)) begin
      stale_d = stale_q - CW'(1);
    end

    if (redirect_in) begin
      // Everything still outstanding after this cycle belongs to the old path.
      stale_d    = inflight_d;
      count_d    = '0;
      rd_ptr_d   = wr_ptr_q;
      fetch_pc_d = redirect_target;
      resp_pc_d  = redirect_target;
    end
  end

  // Control state registers.
  always_ff @(posedge ms_riscv32_mp_clk_in or negedge ms_riscv32_mp_rst_n_in) begin
    if (!ms_riscv32_mp_rst_n_in) begin
      fetch_pc_q <= RESET_PC;
      resp_pc_q  <= RESET_PC;
      count_q    <= '0;
      inflight_q <= '0;
      stale_q    <= '0;
      rd_ptr_q   <= '0;
      wr_ptr_q   <= '0;
    end else begin
      fetch_pc_q <= fetch_pc_d;
      resp_pc_q  <= resp_pc_d;
      count_q    <= count_d;
      inflight_q <= inflight_d;
      stale_q    <= stale_d;
      rd_ptr_q   <= rd_ptr_d;
      wr_ptr_q   <= wr_ptr_d;
    end
  end

  // Queue storage; cleared on reset so the head outputs show reset values at once.
  always_ff @(posedge ms_riscv32_mp_clk_in or negedge ms_riscv32_mp_rst_n_in) begin
    if (!ms_riscv32_mp_rst_n_in) begin
      for (int i = 0; i < DEPTH; i++) begin
        instr_mem_q[i] <= '0;
        pc_mem_q[i]    <= RESET_PC;
      end
    end else if (push) begin
      instr_mem_q[wr_ptr_q] <= imem_rdata_in;
      pc_mem_q[wr_ptr_q]    <= resp_pc_q;
    end
  end

endmodule
